// File: rtl/cpu7_ifu_fcl_if.sv
// cpu7_ifu_fcl_if: instruction-fetch request/response bus between the fetch control unit and the memory side
interface cpu7_ifu_fcl_if;
  logic inst_req;
  logic [31:0] inst_addr;
  logic inst_addr_ok;
  logic inst_cancel;
  logic inst_valid_f;
  logic [31:0] inst_rdata_f;
  logic inst_ex;
  logic [5:0] inst_exccode;
  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_valid_f, inst_rdata_f, inst_ex, inst_exccode
  );
  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_valid_f, inst_rdata_f, inst_ex, inst_exccode
  );
endinterface

// File: rtl/cpu7_ifu_fcl.sv
// cpu7_ifu_fcl: fetch control - request generation, redirect/cancel of stale fetches, PC-tagged instruction buffer to decode
module cpu7_ifu_fcl #(
  parameter int IBUF_DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic [31:0] pc_init,
  input  logic exu_ifu_except,
  input  logic [31:0] exu_ifu_eentry,
  input  logic exu_ifu_ertn_e,
  input  logic [31:0] exu_ifu_era,
  input  logic exu_ifu_br_taken,
  input  logic [31:0] exu_ifu_br_target,
  input  logic exu_ifu_stall_req,
  cpu7_ifu_fcl_if.master bus,
  output logic fcl_dec_vld_d,
  output logic [31:0] fcl_dec_inst_d,
  output logic [31:0] fcl_dec_pc_d,
  output logic fcl_dec_ex_d,
  output logic [5:0] fcl_dec_exccode_d
);
  localparam int AW = IBUF_DEPTH > 1 ? $clog2(IBUF_DEPTH) : 1;
  typedef enum logic [1:0] {BOOT, RUN, EXHOLD} state_t;
  state_t state;
  logic [31:0] fetch_pc, target;
  logic [CNT_W-1:0] outstanding, drop_cnt, buf_count, out_nxt;
  logic [AW-1:0] tag_wr, tag_rd, buf_wr, buf_rd;
  logic [31:0] tag_pc [IBUF_DEPTH];
  logic [31:0] buf_inst [IBUF_DEPTH];
  logic [31:0] buf_pc [IBUF_DEPTH];
  logic buf_ex [IBUF_DEPTH];
  logic [5:0] buf_code [IBUF_DEPTH];
  logic redirect, accept, resp, drop, push, pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(IBUF_DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  // Outstanding plus buffered never exceeds the buffer depth, so every response always has a free slot
  always_comb begin
    redirect = exu_ifu_except | exu_ifu_ertn_e | exu_ifu_br_taken;
    target = exu_ifu_except ? exu_ifu_eentry : exu_ifu_ertn_e ? exu_ifu_era : exu_ifu_br_target;
    bus.inst_req = state == RUN && !redirect &&
                   ({1'b0, outstanding} + {1'b0, buf_count} < (CNT_W+1)'(IBUF_DEPTH));
    bus.inst_addr = fetch_pc;
    accept = bus.inst_req & bus.inst_addr_ok;
    resp = bus.inst_valid_f & (outstanding != '0);
    drop = resp & (drop_cnt != '0);
    push = resp & ~drop & ~redirect;
    fcl_dec_vld_d = (buf_count != '0) & ~redirect;
    pop = fcl_dec_vld_d & ~exu_ifu_stall_req;
    out_nxt = outstanding + CNT_W'(accept) - CNT_W'(resp);
    bus.inst_cancel = redirect & (out_nxt != '0);
    fcl_dec_inst_d = buf_inst[buf_rd];
    fcl_dec_pc_d = buf_pc[buf_rd];
    fcl_dec_ex_d = buf_ex[buf_rd];
    fcl_dec_exccode_d = buf_code[buf_rd];
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= BOOT;
      fetch_pc <= '0;
      outstanding <= '0;
      drop_cnt <= '0;
      buf_count <= '0;
      tag_wr <= '0;
      tag_rd <= '0;
      buf_wr <= '0;
      buf_rd <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        tag_pc[i] <= '0;
        buf_inst[i] <= '0;
        buf_pc[i] <= '0;
        buf_ex[i] <= 1'b0;
        buf_code[i] <= '0;
      end
    end else begin
      outstanding <= out_nxt;
      if (accept) begin
        tag_pc[tag_wr] <= fetch_pc;
        tag_wr <= inc(tag_wr);
      end
      if (resp) tag_rd <= inc(tag_rd);
      if (push) begin
        buf_inst[buf_wr] <= bus.inst_rdata_f;
        buf_pc[buf_wr] <= tag_pc[tag_rd];
        buf_ex[buf_wr] <= bus.inst_ex;
        buf_code[buf_wr] <= bus.inst_exccode;
        buf_wr <= inc(buf_wr);
      end
      // Stale tags stay in the tag FIFO; drop_cnt retires them as their responses return
      if (redirect) begin
        fetch_pc <= target;
        state <= RUN;
        drop_cnt <= out_nxt;
        buf_count <= '0;
        buf_rd <= buf_wr;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (drop) drop_cnt <= drop_cnt - CNT_W'(1);
        buf_count <= buf_count + CNT_W'(push) - CNT_W'(pop);
        if (pop) buf_rd <= inc(buf_rd);
        if (state == BOOT) begin
          fetch_pc <= pc_init;
          state <= RUN;
        end else if (push && bus.inst_ex) begin
          state <= EXHOLD;
        end
      end
    end
  end
endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// tb_cpu7_ifu_fcl: randomized bench; a bus responder plus a program-order model of the decoded PC stream
module tb_cpu7_ifu_fcl;
  localparam logic [31:0] K = 32'h5A5A_A5A5;
  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic ex; logic [5:0] code; int seg; int pos; } dec_t;
  logic clock = 1'b0;
  logic resetn;
  logic [31:0] pc_init, eentry, era, br_target;
  logic except, ertn, br, stall;
  logic vld_d, ex_d;
  logic [31:0] inst_d, pc_d;
  logic [5:0] code_d;
  cpu7_ifu_fcl_if bus();
  cpu7_ifu_fcl dut (
    .clock(clock), .resetn(resetn), .pc_init(pc_init),
    .exu_ifu_except(except), .exu_ifu_eentry(eentry),
    .exu_ifu_ertn_e(ertn), .exu_ifu_era(era),
    .exu_ifu_br_taken(br), .exu_ifu_br_target(br_target),
    .exu_ifu_stall_req(stall), .bus(bus),
    .fcl_dec_vld_d(vld_d), .fcl_dec_inst_d(inst_d), .fcl_dec_pc_d(pc_d),
    .fcl_dec_ex_d(ex_d), .fcl_dec_exccode_d(code_d)
  );
  always #5 clock = ~clock;
  int tests = 0, fails = 0;
  int ok_pct = 100, resp_pct = 100, lat = 1;
  logic [31:0] ex_addr = 32'hFFFF_FFFF;
  int cyc_n = 0, max_pend = 0, n_cancel = 0, n_resp = 0;
  bit stray = 0;
  logic o_req, o_cancel, o_vld, o_ex;
  logic [31:0] o_addr, o_inst, o_pc;
  logic [5:0] o_code;
  req_t pend[$];
  dec_t dec_q[$];
  logic [31:0] seg_q[$];
  int seg_cnt[$];
  logic cxl_got[$], cxl_exp[$];

  function automatic logic [31:0] exp_pc(input int seg, input int pos);
    return seg_q[seg] + 32'(pos) * 32'd4;
  endfunction

  // One clock: drive the responder, sample outputs at negedge, update the model
  task automatic tick();
    logic [31:0] a;
    dec_t d;
    req_t r;
    bus.inst_addr_ok = ($urandom_range(0, 99) < ok_pct);
    bus.inst_valid_f = 1'b0;
    bus.inst_rdata_f = '0;
    bus.inst_ex = 1'b0;
    bus.inst_exccode = '0;
    if (resetn && stray) begin
      bus.inst_valid_f = 1'b1;
      bus.inst_rdata_f = 32'hDEAD_BEEF;
      stray = 0;
    end else if (resetn && pend.size() != 0 && pend[0].due <= cyc_n && $urandom_range(0, 99) < resp_pct) begin
      a = pend[0].addr;
      pend.pop_front();
      bus.inst_valid_f = 1'b1;
      bus.inst_rdata_f = a ^ K;
      bus.inst_ex = (a == ex_addr);
      bus.inst_exccode = (a == ex_addr) ? 6'h08 : 6'h00;
      n_resp++;
    end
    @(negedge clock);
    o_req = bus.inst_req; o_addr = bus.inst_addr; o_cancel = bus.inst_cancel;
    o_vld = vld_d; o_inst = inst_d; o_pc = pc_d; o_ex = ex_d; o_code = code_d;
    if (!resetn) begin
      if (pend.size() != 0) stray = 1;
      pend.delete();
      dec_q.delete();
      seg_q.delete(); seg_q.push_back(pc_init);
      seg_cnt.delete(); seg_cnt.push_back(0);
    end else begin
      if (o_req === 1'b1 && bus.inst_addr_ok) begin
        r.addr = o_addr; r.due = cyc_n + lat;
        pend.push_back(r);
      end
      if (pend.size() > max_pend) max_pend = pend.size();
      if (o_vld === 1'b1 && !stall) begin
        d.pc = o_pc; d.inst = o_inst; d.ex = o_ex; d.code = o_code;
        d.seg = seg_q.size() - 1; d.pos = seg_cnt[seg_cnt.size() - 1];
        dec_q.push_back(d);
        seg_cnt[seg_cnt.size() - 1] = seg_cnt[seg_cnt.size() - 1] + 1;
      end
      if (except || ertn || br) begin
        seg_q.push_back(except ? eentry : ertn ? era : br_target);
        seg_cnt.push_back(0);
        cxl_got.push_back(o_cancel);
        cxl_exp.push_back(pend.size() != 0);
      end
      if (o_cancel === 1'b1) n_cancel++;
    end
    @(posedge clock); #1;
    cyc_n++;
    except = 0; ertn = 0; br = 0;
  endtask

  task automatic test_reset();
    pc_init = 32'h1C00_0000; resetn = 0; ok_pct = 100; resp_pct = 100; lat = 1; stall = 0;
    tick(); tick();
    tests++; if (o_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", o_req); end
    tests++; if (o_cancel !== 1'b0) begin fails++; $display("FAIL reset_cancel got=%b exp=0", o_cancel); end
    tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL reset_vld got=%b exp=0", o_vld); end
    tests++; if (o_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", o_addr); end
    tests++; if ({o_inst, o_pc, o_ex, o_code} !== '0) begin fails++; $display("FAIL reset_data got=%h/%h/%b/%h exp=0", o_inst, o_pc, o_ex, o_code); end
    resetn = 1; tick();
    tests++; if (o_req !== 1'b0) begin fails++; $display("FAIL boot_req got=%b exp=0", o_req); end
    tick();
    tests++; if (o_req !== 1'b1 || o_addr !== 32'h1C00_0000) begin fails++; $display("FAIL first_req got=%b/%h exp=1/1c000000", o_req, o_addr); end
  endtask

  task automatic test_stream();
    max_pend = 0;
    repeat (24) tick();
    tests++; if (dec_q.size() < 6) begin fails++; $display("FAIL stream_count got=%0d exp>=6", dec_q.size()); end
    tests++; if (max_pend > 2) begin fails++; $display("FAIL stream_outstanding got=%0d exp<=2", max_pend); end
    foreach (dec_q[i]) begin
      tests++;
      if (dec_q[i].pc !== 32'h1C00_0000 + 32'(i) * 32'd4 || dec_q[i].inst !== (dec_q[i].pc ^ K)) begin
        fails++; $display("FAIL stream_pc[%0d] got=%h/%h exp=%h", i, dec_q[i].pc, dec_q[i].inst, 32'h1C00_0000 + 32'(i) * 32'd4);
      end
    end
  endtask

  task automatic test_branch_cancel();
    int first, c0, r0;
    resp_pct = 0; stall = 0;
    for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
    tests++; if (pend.size() != 2) begin fails++; $display("FAIL bc_setup got=%0d exp=2 outstanding", pend.size()); end
    first = dec_q.size(); c0 = n_cancel;
    br_target = 32'h1C00_0100; br = 1; tick();
    tests++; if (o_cancel !== 1'b1) begin fails++; $display("FAIL bc_cancel got=%b exp=1", o_cancel); end
    resp_pct = 100; r0 = n_resp;
    for (int i = 0; i < 20 && dec_q.size() <= first; i++) tick();
    tests++;
    if (dec_q.size() <= first) begin
      fails++; $display("FAIL bc_timeout got=no decode exp=decode");
    end else if (dec_q[first].pc !== 32'h1C00_0100 || dec_q[first].inst !== (32'h1C00_0100 ^ K)) begin
      fails++; $display("FAIL bc_first_pc got=%h/%h exp=1c000100", dec_q[first].pc, dec_q[first].inst);
    end
    tests++; if (n_resp - r0 < 3) begin fails++; $display("FAIL bc_drops got=%0d responses exp>=3", n_resp - r0); end
    tests++; if (n_cancel - c0 != 1) begin fails++; $display("FAIL bc_cancel_len got=%0d exp=1", n_cancel - c0); end
  endtask

  task automatic test_priority();
    int first;
    first = dec_q.size();
    eentry = 32'h1C00_8000; br_target = 32'h1C00_0200; except = 1; br = 1; tick();
    tick();
    tests++; if (o_addr !== 32'h1C00_8000) begin fails++; $display("FAIL prio_exc_addr got=%h exp=1c008000", o_addr); end
    for (int i = 0; i < 20 && dec_q.size() <= first; i++) tick();
    tests++;
    if (dec_q.size() <= first || dec_q[first].pc !== 32'h1C00_8000) begin
      fails++; $display("FAIL prio_exc_pc got=%h exp=1c008000", dec_q.size() > first ? dec_q[first].pc : 32'hx);
    end
    first = dec_q.size();
    era = 32'h1C00_0400; br_target = 32'h1C00_0600; ertn = 1; br = 1; tick();
    tick();
    tests++; if (o_addr !== 32'h1C00_0400) begin fails++; $display("FAIL prio_ertn_addr got=%h exp=1c000400", o_addr); end
    for (int i = 0; i < 20 && dec_q.size() <= first; i++) tick();
    tests++;
    if (dec_q.size() <= first || dec_q[first].pc !== 32'h1C00_0400) begin
      fails++; $display("FAIL prio_ertn_pc got=%h exp=1c000400", dec_q.size() > first ? dec_q[first].pc : 32'hx);
    end
  endtask

  task automatic test_stall();
    logic [31:0] hp;
    int idx, s;
    stall = 1;
    repeat (3) tick();
    hp = o_pc;
    tests++; if (o_vld !== 1'b1) begin fails++; $display("FAIL stall_vld got=%b exp=1", o_vld); end
    repeat (5) begin
      tick();
      tests++;
      if (o_vld !== 1'b1 || o_pc !== hp || o_inst !== (hp ^ K)) begin
        fails++; $display("FAIL stall_hold got=%b/%h/%h exp=1/%h", o_vld, o_pc, o_inst, hp);
      end
    end
    tests++; if (o_req !== 1'b0) begin fails++; $display("FAIL stall_full_req got=%b exp=0", o_req); end
    stall = 0; idx = dec_q.size();
    repeat (12) tick();
    tests++;
    if (dec_q.size() < idx + 2) begin
      fails++; $display("FAIL stall_drain got=%0d exp>=%0d", dec_q.size(), idx + 2);
    end else if (dec_q[idx].pc !== hp || dec_q[idx + 1].pc !== hp + 32'd4) begin
      fails++; $display("FAIL stall_order got=%h,%h exp=%h,%h", dec_q[idx].pc, dec_q[idx + 1].pc, hp, hp + 32'd4);
    end
    s = seg_q.size() - 1;
    foreach (dec_q[i]) if (dec_q[i].seg == s) begin
      tests++;
      if (dec_q[i].pc !== exp_pc(s, dec_q[i].pos)) begin
        fails++; $display("FAIL stall_seq[%0d] got=%h exp=%h", i, dec_q[i].pc, exp_pc(s, dec_q[i].pos));
      end
    end
  endtask

  task automatic test_exception();
    bit found = 0;
    int first;
    stall = 0; ex_addr = 32'h1C00_0308;
    br_target = 32'h1C00_0300; br = 1; tick();
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (dec_q.size() != 0 && dec_q[dec_q.size() - 1].ex === 1'b1) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL ex_timeout got=no ex decode exp=ex decode");
    end else if (dec_q[dec_q.size() - 1].pc !== 32'h1C00_0308 || dec_q[dec_q.size() - 1].code !== 6'h08) begin
      fails++; $display("FAIL ex_entry got=%h/%h exp=1c000308/08", dec_q[dec_q.size() - 1].pc, dec_q[dec_q.size() - 1].code);
    end
    repeat (8) begin
      tick();
      tests++; if (o_req !== 1'b0) begin fails++; $display("FAIL exhold_req got=%b exp=0", o_req); end
    end
    ex_addr = 32'hFFFF_FFFF; first = dec_q.size();
    era = 32'h1C00_0040; ertn = 1; tick();
    tick();
    tests++; if (o_req !== 1'b1 || o_addr !== 32'h1C00_0040) begin fails++; $display("FAIL ertn_resume got=%b/%h exp=1/1c000040", o_req, o_addr); end
    for (int i = 0; i < 20 && dec_q.size() <= first; i++) tick();
    tests++;
    if (dec_q.size() <= first || dec_q[first].pc !== 32'h1C00_0040 || dec_q[first].ex !== 1'b0) begin
      fails++; $display("FAIL ertn_pc got=%h exp=1c000040", dec_q.size() > first ? dec_q[first].pc : 32'hx);
    end
  endtask

  task automatic test_mid_reset();
    lat = 3; repeat (6) tick();
    pc_init = 32'h1C00_1000; resetn = 0; tick();
    resetn = 1; tick();
    tests++; if (o_req !== 1'b0 || o_vld !== 1'b0 || o_addr !== 32'h0 || o_pc !== 32'h0) begin
      fails++; $display("FAIL midrst_boot got=%b/%b/%h/%h exp=0/0/0/0", o_req, o_vld, o_addr, o_pc);
    end
    lat = 1; tick();
    tests++; if (o_req !== 1'b1 || o_addr !== 32'h1C00_1000) begin fails++; $display("FAIL midrst_req got=%b/%h exp=1/1c001000", o_req, o_addr); end
    repeat (20) tick();
    tests++; if (dec_q.size() < 4) begin fails++; $display("FAIL midrst_count got=%0d exp>=4", dec_q.size()); end
    foreach (dec_q[i]) begin
      tests++;
      if (dec_q[i].pc !== 32'h1C00_1000 + 32'(i) * 32'd4 || dec_q[i].inst !== (dec_q[i].pc ^ K)) begin
        fails++; $display("FAIL midrst_pc[%0d] got=%h/%h exp=%h", i, dec_q[i].pc, dec_q[i].inst, 32'h1C00_1000 + 32'(i) * 32'd4);
      end
    end
  endtask

  task automatic test_random();
    max_pend = 0; ok_pct = 70; resp_pct = 60;
    cxl_got.delete(); cxl_exp.delete();
    repeat (1500) begin
      lat = $urandom_range(1, 3);
      stall = ($urandom_range(0, 99) < 30);
      except = ($urandom_range(0, 99) < 2); eentry = $urandom & 32'hFFFF_FFFC;
      ertn = ($urandom_range(0, 99) < 2); era = $urandom & 32'hFFFF_FFFC;
      br = ($urandom_range(0, 99) < 3); br_target = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    stall = 0;
    tests++; if (dec_q.size() < 50) begin fails++; $display("FAIL rand_progress got=%0d exp>=50", dec_q.size()); end
    tests++; if (max_pend > 2) begin fails++; $display("FAIL rand_outstanding got=%0d exp<=2", max_pend); end
    foreach (dec_q[i]) begin
      tests++;
      if (dec_q[i].pc !== exp_pc(dec_q[i].seg, dec_q[i].pos) || dec_q[i].inst !== (dec_q[i].pc ^ K) || dec_q[i].ex !== 1'b0) begin
        fails++; $display("FAIL rand_dec[%0d] got=%h/%h exp=%h", i, dec_q[i].pc, dec_q[i].inst, exp_pc(dec_q[i].seg, dec_q[i].pos));
      end
    end
    foreach (cxl_got[i]) begin
      tests++;
      if (cxl_got[i] !== cxl_exp[i]) begin fails++; $display("FAIL rand_cancel[%0d] got=%b exp=%b", i, cxl_got[i], cxl_exp[i]); end
    end
  endtask

  initial begin
    resetn = 0; pc_init = '0; eentry = '0; era = '0; br_target = '0;
    except = 0; ertn = 0; br = 0; stall = 0;
    bus.inst_addr_ok = 0; bus.inst_valid_f = 0; bus.inst_rdata_f = '0; bus.inst_ex = 0; bus.inst_exccode = '0;
    @(posedge clock); #1;
    test_reset();
    test_stream();
    test_branch_cancel();
    test_priority();
    test_stall();
    test_exception();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu7_ifu_fcl.md
Name: cpu7_ifu_fcl

Overview:
Fetch control unit for the cpu7 IFU. It generates the instruction-fetch request stream on the inst_req/inst_addr_ok/inst_valid_f interface and tracks outstanding requests by PC. It resolves redirects (exception, ertn, branch) and discards stale responses after cancel. Returned instructions are buffered in a small queue and presented to the decode stage with their PC, honouring the EXU stall.

Parameters:
IBUF_DEPTH, 2, instruction buffer entries; also the cap on in-flight requests plus buffered entries
CNT_W, 2, width of occupancy, outstanding and drop counters; must hold values 0..IBUF_DEPTH

Ports:
clock  in  1  core clock
resetn  in  1  synchronous active-low reset
pc_init  in  32  boot PC
exu_ifu_except  in  1  exception redirect
exu_ifu_eentry  in  32  exception target
exu_ifu_ertn_e  in  1  ertn redirect
exu_ifu_era  in  32  ertn target
exu_ifu_br_taken  in  1  branch redirect
exu_ifu_br_target  in  32  branch target
exu_ifu_stall_req  in  1  decode must hold its current instruction
inst_req  out  1  fetch request
inst_addr  out  32  fetch address
inst_addr_ok  in  1  request accepted
inst_cancel  out  1  one-cycle pulse: invalidate all in-flight requests
inst_valid_f  in  1  response valid
inst_rdata_f  in  32  response instruction
inst_ex  in  1  fetch exception on response
inst_exccode  in  6  fetch exception code
fcl_dec_vld_d  out  1  instruction valid at decode
fcl_dec_inst_d  out  32  instruction
fcl_dec_pc_d  out  32  its PC
fcl_dec_ex_d  out  1  fetch exception flag
fcl_dec_exccode_d  out  6  exception code

Behaviour:
- Reset (resetn=0 at a clock edge): state=BOOT; fetch_pc, outstanding, drop_cnt, buffer count=0; inst_req=0, inst_cancel=0, fcl_dec_vld_d=0. All data outputs read 0.
- BOOT: one cycle. fetch_pc<=pc_init. Next state is RUN.
- RUN:
  - inst_req=1 when (outstanding + buf_count) < IBUF_DEPTH and no redirect this cycle.
  - inst_addr=fetch_pc at all times.
  - Accept when inst_req & inst_addr_ok: push fetch_pc into the PC tag FIFO, outstanding+=1, fetch_pc+=4 (32-bit wrap).
  - inst_req may drop without an accept; the address is held until accepted or redirected.
- Response handling (any state), on inst_valid_f:
  - Pop the tag FIFO and set outstanding-=1.
  - If drop_cnt!=0: drop_cnt-=1 and discard the response.
  - Otherwise push {inst, tag pc, inst_ex, exccode} into the buffer.
  - If the pushed entry has inst_ex=1, go to EXHOLD.
- EXHOLD: inst_req=0 until a redirect occurs.
- Redirect priority: except > ertn > br_taken. Only the highest-priority target is used. On any redirect:
  - fetch_pc<=target; state<=RUN.
  - Buffer flushed; fcl_dec_vld_d forced 0 in that cycle.
  - drop_cnt<=outstanding after this cycle's accept and response, i.e. any request accepted in the redirect cycle is stale, and any response arriving in the redirect cycle is discarded.
  - inst_cancel=1 for that cycle iff the resulting drop_cnt!=0.
  - The tag FIFO keeps stale tags; they are popped as drops.
- Decode output: head of the buffer, combinational from buffer registers. fcl_dec_vld_d=(buf_count!=0) & ~redirect.
  - Head popped when vld & ~exu_ifu_stall_req.
  - Push and pop in the same cycle keep buf_count unchanged.
- Latency: response at cycle N is visible at decode at N+1 at the earliest.
- Overflow is impossible by construction. A response with an empty tag FIFO is a protocol error; the response is ignored.
- Reset mid-operation clears all state; a response arriving after reset with outstanding=0 is ignored.

Test Plan:
- Reset with pc_init=0x1C000000, then release -> BOOT 1 cycle. inst_req=1 with inst_addr=0x1C000000 on the 2nd cycle after release.
- addr_ok always 1, responses 1 cycle later, no stall -> decode sees PCs 0x1C000000, 04, 08… consecutively. inst_req never exceeds 2 outstanding.
- Two accepted requests outstanding, then br_taken to 0x1C000100 -> inst_cancel=1 for 1 cycle; next 2 responses discarded; first decoded PC=0x1C000100.
- except and br_taken in the same cycle, eentry=0x1C008000 -> fetch redirects to 0x1C008000; branch target ignored.
- Stall held 5 cycles -> buffer fills to 2, inst_req=0, the decode instruction is held steady. After release, entries drain in order with no loss.
- Response with inst_ex=1, exccode=0x08 -> decode sees ex_d=1, exccode_d=0x08; inst_req stays 0 until ertn to era=0x1C000040, after which fetch resumes at that address.
